// File: rtl/full_subtractor.sv
// Registered full subtractor: {borr,diff} <= a - b - c, built as a per-bit ripple-borrow chain.
// WIDTH=1 is the leaf cell; wider instances behave like a chain of such cells.
module full_subtractor #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  output logic [WIDTH-1:0] diff,
  output logic             borr
);

  logic [WIDTH-1:0] diff_next;
  logic             borr_next;

  // The borrow ripples from bit 0 upwards; bin carries it between iterations.
  always_comb begin : ripple
    logic bin;
    diff_next = '0;
    bin       = c;
    for (int i = 0; i < WIDTH; i++) begin
      diff_next[i] = a[i] ^ b[i] ^ bin;
      bin          = (~a[i] & b[i]) | (~a[i] & bin) | (b[i] & bin);
    end
    borr_next = bin;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      diff <= '0;
      borr <= 1'b0;
    end else begin
      diff <= diff_next;
      borr <= borr_next;
    end
  end

endmodule

// File: tb/tb_full_subtractor.sv
// Self-checking bench for full_subtractor: WIDTH=1 and WIDTH=8 instances share clock and reset.
// Expected results come from integer arithmetic on the operands.
module tb_full_subtractor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a1, b1, c1, d1, br1;
  logic [7:0] a8, b8, d8;
  logic       c8, br8;

  int compared   = 0;
  int mismatched = 0;

  full_subtractor #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .c(c1), .diff(d1), .borr(br1)
  );

  full_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .c(c8), .diff(d8), .borr(br8)
  );

  always #5 clk = ~clk;

  // Reference: diff = (a-b-c) mod 2^w, borr = a < b+c with integer arithmetic.
  function automatic int ref_diff(int a, int b, int c, int w);
    int r;
    r = a - b - c;
    if (r < 0) r = r + (1 << w);
    return r;
  endfunction

  function automatic bit ref_borr(int a, int b, int c);
    return a < (b + c);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a1 = 1'b1; b1 = 1'b0; c1 = 1'b0;
    a8 = 8'h01; b8 = 8'h00; c8 = 1'b0;
    for (int e = 0; e < 2; e++) begin
      tick();
      compared++;
      if ({br1, d1} !== 2'b00) begin
        mismatched++;
        $display("[TB] FAIL reset_w1 edge %0d: got diff=%b borr=%b, expected diff=0 borr=0", e, d1, br1);
      end
      compared++;
      if ({br8, d8} !== 9'h000) begin
        mismatched++;
        $display("[TB] FAIL reset_w8 edge %0d: got diff=%h borr=%b, expected diff=00 borr=0", e, d8, br8);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_truth_table();
    int ed;
    bit eb;
    for (int v = 0; v < 8; v++) begin
      a1 = v[2]; b1 = v[1]; c1 = v[0];
      ed = ref_diff(v[2], v[1], v[0], 1);
      eb = ref_borr(v[2], v[1], v[0]);
      tick();
      compared++;
      if (d1 !== ed[0] || br1 !== eb) begin
        mismatched++;
        $display("[TB] FAIL truth_%0d%0d%0d: got diff=%b borr=%b, expected diff=%0d borr=%0d",
                 v[2], v[1], v[0], d1, br1, ed[0], eb);
      end
    end
    // Spot value: 011 -> diff=0, borr=1
    a1 = 1'b0; b1 = 1'b1; c1 = 1'b1;
    tick();
    compared++;
    if ({br1, d1} !== 2'b10) begin
      mismatched++;
      $display("[TB] FAIL truth_011_const: got diff=%b borr=%b, expected diff=0 borr=1", d1, br1);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp;
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0) begin a1 = 1'b1; b1 = 1'b0; c1 = 1'b0; exp = 2'b01; end
      else            begin a1 = 1'b0; b1 = 1'b0; c1 = 1'b1; exp = 2'b11; end
      tick();
      compared++;
      if ({br1, d1} !== exp) begin
        mismatched++;
        $display("[TB] FAIL b2b_cycle%0d: got borr,diff=%b%b, expected %b", k, br1, d1, exp);
      end
      // Flip to the next pattern early; outputs must hold until the next edge.
      {a1, b1, c1} = (k % 2 == 0) ? 3'b001 : 3'b100;
      #2;
      compared++;
      if ({br1, d1} !== exp) begin
        mismatched++;
        $display("[TB] FAIL b2b_hold%0d: got borr,diff=%b%b, expected %b", k, br1, d1, exp);
      end
    end
  endtask

  task automatic test_reset_midstream();
    a1 = 1'b1; b1 = 1'b0; c1 = 1'b0;
    tick();
    compared++;
    if ({br1, d1} !== 2'b01) begin
      mismatched++;
      $display("[TB] FAIL mid_pre: got borr,diff=%b%b, expected 01", br1, d1);
    end
    a1 = 1'b0; b1 = 1'b1; c1 = 1'b0;
    rst_n = 1'b0;
    tick();
    compared++;
    if ({br1, d1} !== 2'b00) begin
      mismatched++;
      $display("[TB] FAIL mid_reset: got borr,diff=%b%b, expected 00", br1, d1);
    end
    rst_n = 1'b1;
    a1 = 1'b1; b1 = 1'b0; c1 = 1'b1;
    tick();
    compared++;
    if ({br1, d1} !== 2'b00) begin
      mismatched++;
      $display("[TB] FAIL mid_release_101: got borr,diff=%b%b, expected 00", br1, d1);
    end
    a1 = 1'b0; b1 = 1'b1; c1 = 1'b0;
    tick();
    compared++;
    if ({br1, d1} !== 2'b11) begin
      mismatched++;
      $display("[TB] FAIL mid_release_010: got borr,diff=%b%b, expected 11", br1, d1);
    end
  endtask

  task automatic test_width8_boundaries();
    logic [7:0] ta [4] = '{8'h00, 8'h50, 8'h5A, 8'h5A};
    logic [7:0] tb [4] = '{8'hFF, 8'h20, 8'h5A, 8'h5A};
    logic       tc [4] = '{1'b1,  1'b1,  1'b0,  1'b1};
    logic [7:0] ed [4] = '{8'h00, 8'h2F, 8'h00, 8'hFF};
    logic       eb [4] = '{1'b1,  1'b0,  1'b0,  1'b1};
    for (int k = 0; k < 4; k++) begin
      a8 = ta[k]; b8 = tb[k]; c8 = tc[k];
      tick();
      compared++;
      if (d8 !== ed[k] || br8 !== eb[k]) begin
        mismatched++;
        $display("[TB] FAIL w8_boundary%0d: got diff=%h borr=%b, expected diff=%h borr=%b",
                 k, d8, br8, ed[k], eb[k]);
      end
    end
  endtask

  task automatic test_width8_random();
    int ra, rb, rc, ed;
    bit eb;
    int bad = 0;
    for (int k = 0; k < 1000; k++) begin
      ra = int'($urandom_range(255));
      rb = int'($urandom_range(255));
      rc = int'($urandom_range(1));
      a8 = 8'(ra); b8 = 8'(rb); c8 = rc[0];
      a1 = ra[0]; b1 = rb[0]; c1 = rc[0];
      tick();
      ed = ref_diff(ra, rb, rc, 8);
      eb = ref_borr(ra, rb, rc);
      compared++;
      if (d8 !== 8'(ed) || br8 !== eb) begin
        mismatched++;
        if (bad < 10)
          $display("[TB] FAIL w8_random a=%h b=%h c=%0d: got diff=%h borr=%b, expected diff=%h borr=%b",
                   ra[7:0], rb[7:0], rc, d8, br8, ed[7:0], eb);
        bad++;
      end
      ed = ref_diff(ra % 2, rb % 2, rc, 1);
      eb = ref_borr(ra % 2, rb % 2, rc);
      compared++;
      if (d1 !== ed[0] || br1 !== eb) begin
        mismatched++;
        if (bad < 10)
          $display("[TB] FAIL w1_random a=%0d b=%0d c=%0d: got diff=%b borr=%b, expected diff=%0d borr=%0d",
                   ra % 2, rb % 2, rc, d1, br1, ed[0], eb);
        bad++;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
    a8 = 8'h00; b8 = 8'h00; c8 = 1'b0;
    @(negedge clk);
    test_reset();
    test_truth_table();
    test_back_to_back();
    test_reset_midstream();
    test_width8_boundaries();
    test_width8_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
